// File: rtl/instr_loader.sv
// Byte-stream boot loader: header word count, little-endian payload words
// written to instruction memory, XOR checksum gate on CPU release.
module instr_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

  logic [2:0]            state;
  logic [7:0]            wleft;
  logic [7:0]            acc;
  logic [1:0]            bidx;
  logic [ADDR_WIDTH-1:0] widx;
  logic [23:0]           asm_q;
  logic                  xfer;

  assign byte_ready = (state == S_HDR) ||
                      (state == S_LOAD) ||
                      (state == S_CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign cpu_hold   = (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wleft     <= '0;
      acc       <= '0;
      bidx      <= '0;
      widx      <= '0;
      asm_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_HDR;
            wleft <= '0;
            acc   <= '0;
            bidx  <= '0;
            widx  <= '0;
            asm_q <= '0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            wleft <= byte_data;
            if ({24'd0, byte_data} > CAP)
              state <= S_ERR;
            else if (byte_data == 8'd0)
              state <= S_CHECK;
            else
              state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            acc  <= acc ^ byte_data;
            bidx <= bidx + 2'd1;
            // first three bytes shift in from the top; the fourth completes the word
            if (bidx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx;
              mem_wdata <= {byte_data, asm_q};
              widx      <= widx + 1'b1;
              wleft     <= wleft - 8'd1;
              if (wleft == 8'd1)
                state <= S_CHECK;
            end else begin
              asm_q <= {byte_data, asm_q[23:8]};
            end
          end
        end
        S_CHECK: begin
          if (xfer)
            state <= (byte_data == acc) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
